data_receiver: RTL and testbench

- Upstream neighbour of the image transmit path.
- Accepts bytes from the UART receiver and writes them into the shared image RAM at consecutive addresses, from 0 through end_add inclusive.
- On completion it raises fin, so the controller can start processing and then transmission.
- Exactly one RAM write port: write-enable, address and data are driven for one cycle per byte.

---
 rtl/data_receiver_pkg.sv | 20 ++
 rtl/data_receiver_if.sv | 22 ++
 rtl/data_receiver_rx_timeout_counter.sv | 36 +++
 rtl/data_receiver.sv | 151 +++++++++++++++
 tb/tb_data_receiver.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_receiver_pkg.sv
// data_receiver_pkg
//   Constants shared by the image receive path:
//     - state_t : the receiver FSM states (2-bit encoding)
//     - ADDR_W_DEF / DATA_W_DEF : default RAM address and UART byte widths
//     - IMG_END_ADDR : last address of a full image in the shared RAM
package data_receiver_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 8;

  localparam logic [ADDR_W_DEF-1:0] IMG_END_ADDR = 18'd262143;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/data_receiver_if.sv
// data_receiver_if
//   Write port of the shared image RAM.
//     addr  : write address
//     wdata : write data
//     wen   : write enable, one cycle per byte
//   master : the writer (data_receiver)
//   slave  : the RAM / observer
interface data_receiver_if
  import data_receiver_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wen;

  modport master (output addr, output wdata, output wen);
  modport slave  (input  addr, input  wdata, input  wen);

endinterface

// File: rtl/data_receiver_rx_timeout_counter.sv
// rx_timeout_counter
//   Counts idle cycles while the receiver waits for the next byte.
//   Only instantiated when RX_TIMEOUT_EN is defined.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clr      : synchronous clear (has priority over en)
//     en       : count this cycle
//     expired  : en is high and the count has reached TIMEOUT_CYCLES-1
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign expired = en && (cnt_reg == LAST);

endmodule

// File: rtl/data_receiver.sv
// data_receiver
//   Writes bytes from the UART receiver into the shared image RAM at
//   addresses 0..end_add, then raises fin.
//   Optional feature macro: RX_TIMEOUT_EN (abort with err after
//   TIMEOUT_CYCLES idle cycles between bytes).
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : begin a reception (honoured only in IDLE)
//     end_add   : last address to write, latched on start
//     rx_data   : received byte, valid with rx_tick
//     rx_tick   : one-cycle new-byte strobe
//     ram       : RAM write port (addr, wdata, wen)
//     busy      : high while waiting for / writing bytes
//     fin       : reception complete, sticky until next start
//     overrun   : sticky, a byte arrived during a write and was dropped
//     err       : sticky timeout flag (0 without RX_TIMEOUT_EN)
module data_receiver
  import data_receiver_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] end_add,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_tick,
  data_receiver_if.master   ram,
  output logic              busy,
  output logic              fin,
  output logic              overrun,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              fin_reg, fin_next;
  logic              overrun_reg, overrun_next;
  logic              err_reg, err_next;
  logic              timeout_hit;

`ifdef RX_TIMEOUT_EN
  // Counter restarts whenever we are outside WAIT (so it is zero on entry)
  // and on every received byte.
  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_reg != S_WAIT) || rx_tick),
    .en      (state_reg == S_WAIT),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      end_reg     <= '0;
      wdata_reg   <= '0;
      fin_reg     <= 1'b0;
      overrun_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      end_reg     <= end_next;
      wdata_reg   <= wdata_next;
      fin_reg     <= fin_next;
      overrun_reg <= overrun_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    end_next     = end_reg;
    wdata_next   = wdata_reg;
    fin_next     = fin_reg;
    overrun_next = overrun_reg;
    err_next     = err_reg;

    case (state_reg)
      S_IDLE: begin
        addr_next = '0;
        if (start) begin
          end_next     = end_add;
          fin_next     = 1'b0;
          overrun_next = 1'b0;
          err_next     = 1'b0;
          state_next   = S_WAIT;
        end
      end

      S_WAIT: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_tick) begin
          wdata_next = rx_data;
          state_next = S_WRITE;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          addr_next  = '0;
          state_next = S_IDLE;
        end
      end

      S_WRITE: begin
        if (rx_tick) begin
          overrun_next = 1'b1;
        end
        // Compare before incrementing so a full-range image never wraps.
        if (addr_reg == end_reg) begin
          fin_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          addr_next  = addr_reg + ADDR_W'(1);
          state_next = S_WAIT;
        end
      end

      S_DONE: begin
        fin_next   = 1'b1;
        addr_next  = '0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ram.addr  = addr_reg;
  assign ram.wdata = wdata_reg;
  assign ram.wen   = (state_reg == S_WRITE);
  assign busy      = (state_reg == S_WAIT) || (state_reg == S_WRITE);
  assign fin       = fin_reg;
  assign overrun   = overrun_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_data_receiver.sv
// tb_data_receiver
//   Self-checking bench for data_receiver. Directed scenarios plus a
//   randomized byte stream compared against a transaction-level model.
//   Honours RX_TIMEOUT_EN (timeout scenario) when defined.
module tb_data_receiver;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] end_add = '0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_tick = 1'b0;
  logic          busy, fin, overrun, err;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] got[$];

  data_receiver_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  data_receiver #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .end_add (end_add),
    .rx_data (rx_data),
    .rx_tick (rx_tick),
    .ram     (ram_if.master),
    .busy    (busy),
    .fin     (fin),
    .overrun (overrun),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Record every RAM write away from the active edge.
  always @(negedge clk) begin
    if (ram_if.wen === 1'b1) got.push_back({ram_if.addr, ram_if.wdata});
  end

  // One clock: drive rx inputs, let an edge pass, return 1 time unit later.
  task automatic step(input logic tk, input logic [DW-1:0] d);
    rx_tick = tk;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_tick = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] e);
    end_add = e;
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rx_tick = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ram_if.addr !== '0) begin errors++; $display("FAIL reset_addr actual=%0h expected=0", ram_if.addr); end
    checks++; if (ram_if.wdata !== '0) begin errors++; $display("FAIL reset_wdata actual=%0h expected=0", ram_if.wdata); end
    checks++; if (ram_if.wen !== 1'b0) begin errors++; $display("FAIL reset_wen actual=%0b expected=0", ram_if.wen); end
    checks++; if ({busy, fin, overrun, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags actual=%b expected=0000", {busy, fin, overrun, err}); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] b [4];
    b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'hC3; b[3] = 8'hD4;
    do_reset();
    do_start(18'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start actual=%0b expected=1", busy); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i]);
      checks++;
      if (ram_if.wen !== 1'b1 || ram_if.addr !== AW'(i) || ram_if.wdata !== b[i]) begin
        errors++;
        $display("FAIL basic_write%0d actual wen=%0b addr=%0h data=%0h expected wen=1 addr=%0h data=%0h",
                 i, ram_if.wen, ram_if.addr, ram_if.wdata, i, b[i]);
      end
      if (i < 3) repeat (49) step(1'b0, '0);
    end
    step(1'b0, '0);
    checks++; if (fin !== 1'b1 || busy !== 1'b0 || ram_if.wen !== 1'b0) begin errors++; $display("FAIL basic_fin actual fin=%0b busy=%0b wen=%0b expected fin=1 busy=0 wen=0", fin, busy, ram_if.wen); end
    repeat (3) step(1'b0, '0);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL basic_write_count actual=%0d expected=4", got.size()); end
  endtask

  task automatic test_single();
    do_reset();
    do_start(18'd0);
    step(1'b1, 8'h55);
    checks++; if (ram_if.wen !== 1'b1 || ram_if.addr !== '0 || ram_if.wdata !== 8'h55) begin errors++; $display("FAIL single_write actual wen=%0b addr=%0h data=%0h expected wen=1 addr=0 data=55", ram_if.wen, ram_if.addr, ram_if.wdata); end
    step(1'b0, '0);
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL single_fin actual=%0b expected=1", fin); end
    step(1'b0, '0);
    step(1'b1, 8'hEE);
    repeat (5) step(1'b0, '0);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL single_extra_tick_ignored actual_writes=%0d expected=1", got.size()); end
    checks++; if (fin !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL single_flags actual fin=%0b busy=%0b ovr=%0b expected fin=1 busy=0 ovr=0", fin, busy, overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    do_start(18'd3);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    repeat (3) step(1'b0, '0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag actual=%0b expected=1", overrun); end
    checks++; if (got.size() != 1 || ram_if.addr !== AW'(1)) begin errors++; $display("FAIL overrun_drop actual writes=%0d addr=%0h expected writes=1 addr=1", got.size(), ram_if.addr); end
    step(1'b1, 8'h33);
    checks++; if (ram_if.wen !== 1'b1 || ram_if.addr !== AW'(1) || ram_if.wdata !== 8'h33) begin errors++; $display("FAIL overrun_next_write actual wen=%0b addr=%0h data=%0h expected wen=1 addr=1 data=33", ram_if.wen, ram_if.addr, ram_if.wdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start(18'd5);
    step(1'b1, 8'hAA);
    repeat (3) step(1'b0, '0);
    step(1'b1, 8'hBB);
    repeat (3) step(1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ram_if.addr !== '0 || ram_if.wdata !== '0 || ram_if.wen !== 1'b0) begin errors++; $display("FAIL async_reset_bus actual addr=%0h data=%0h wen=%0b expected 0 0 0", ram_if.addr, ram_if.wdata, ram_if.wen); end
    checks++; if ({busy, fin, overrun, err} !== 4'b0000) begin errors++; $display("FAIL async_reset_flags actual=%b expected=0000", {busy, fin, overrun, err}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    do_start(18'd5);
    step(1'b1, 8'h77);
    checks++; if (ram_if.wen !== 1'b1 || ram_if.addr !== '0 || ram_if.wdata !== 8'h77) begin errors++; $display("FAIL reset_resume actual wen=%0b addr=%0h data=%0h expected wen=1 addr=0 data=77", ram_if.wen, ram_if.addr, ram_if.wdata); end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start(18'd3);
    step(1'b1, 8'h9A);
`ifdef RX_TIMEOUT_EN
    repeat (TO) step(1'b0, '0);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early actual err=%0b busy=%0b expected err=0 busy=1", err, busy); end
    step(1'b0, '0);
    checks++; if (err !== 1'b1 || fin !== 1'b0 || busy !== 1'b0 || ram_if.addr !== '0) begin errors++; $display("FAIL timeout_abort actual err=%0b fin=%0b busy=%0b addr=%0h expected err=1 fin=0 busy=0 addr=0", err, fin, busy, ram_if.addr); end
    do_start(18'd3);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_clear actual err=%0b busy=%0b expected err=0 busy=1", err, busy); end
`else
    repeat (2 * TO) step(1'b0, '0);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_timeout_wait actual err=%0b busy=%0b expected err=0 busy=1", err, busy); end
`endif
  endtask

  task automatic test_end_change();
    logic [AW+DW-1:0] e;
    do_reset();
    do_start(18'd3);
    end_add = 18'd1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, DW'(8'h40 + i));
      repeat (4) step(1'b0, '0);
      if (i == 1) begin
        start = 1'b1;
        step(1'b0, '0);
        start = 1'b0;
      end
    end
    repeat (3) step(1'b0, '0);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL end_change_count actual=%0d expected=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      e = {AW'(i), DW'(8'h40 + i)};
      checks++; if (got[i] !== e) begin errors++; $display("FAIL end_change_write%0d actual=%0h expected=%0h", i, got[i], e); end
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL end_change_fin actual=%0b expected=1", fin); end
  endtask

  // Model: a byte is taken when the receiver has room left and the
  // previous cycle did not take a byte; a byte right after an accepted one
  // is dropped and flags overrun. Everything after the last byte is ignored.
  task automatic test_random();
    logic [AW+DW-1:0] expq[$];
    int               e, n, len;
    logic             prev, acc, ov, tk;
    logic [DW-1:0]    d;
    for (int it = 0; it < 20; it++) begin
      do_reset();
      expq.delete();
      e = $urandom_range(0, 7);
      n = 0; prev = 1'b0; ov = 1'b0;
      do_start(AW'(e));
      len = $urandom_range(8, 40);
      for (int c = 0; c < len; c++) begin
        tk = 1'($urandom_range(0, 1));
        d = DW'($urandom);
        acc = 1'b0;
        if (tk) begin
          if (prev) ov = 1'b1;
          else if (n <= e) begin
            expq.push_back({AW'(n), d});
            n++;
            acc = 1'b1;
          end
        end
        prev = acc;
        step(tk, d);
      end
      repeat (4) step(1'b0, '0);
      checks++; if (got.size() != expq.size()) begin errors++; $display("FAIL rand%0d_count actual=%0d expected=%0d", it, got.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== expq[i]) begin errors++; $display("FAIL rand%0d_write%0d actual=%0h expected=%0h", it, i, got[i], expq[i]); end
      end
      checks++; if (overrun !== ov) begin errors++; $display("FAIL rand%0d_overrun actual=%0b expected=%0b", it, overrun, ov); end
      checks++; if (fin !== (n == e + 1)) begin errors++; $display("FAIL rand%0d_fin actual=%0b expected=%0b", it, fin, (n == e + 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overrun();
    test_reset_mid();
    test_timeout();
    test_end_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
